// File: rtl/wb_trap_unit.sv
// rtl/wb_trap_unit.sv - write-back stage trap/interrupt/mret sequencer with machine CSRs
module wb_trap_unit #(
   parameter int              XLEN         = 32,
   parameter int              NUM_IRQ      = 4,
   parameter bit              VECTORED_EN  = 1'b1,
   parameter int              FLUSH_CYCLES = 2,
   parameter logic [XLEN-1:0] RESET_MTVEC  = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               retire_valid,
   input  logic [XLEN-1:0]    retire_pc,
   input  logic               retire_exc,
   input  logic [3:0]         retire_exc_code,
   input  logic [XLEN-1:0]    retire_tval,
   input  logic               retire_mret,
   input  logic               irq_sw,
   input  logic               irq_timer,
   input  logic               irq_ext,
   input  logic [NUM_IRQ-1:0] irq_plat,
   input  logic               csr_we,
   input  logic [11:0]        csr_addr,
   input  logic [XLEN-1:0]    csr_wdata,
   output logic [XLEN-1:0]    csr_rdata,
   output logic               wb_kill,
   output logic               trap_take,
   output logic [XLEN-1:0]    trap_pc
);
   typedef enum logic [1:0] {IDLE, REDIR, DRAIN} state_t;

   localparam logic [63:0]     PLAT_MASK = ((64'd1 << NUM_IRQ) - 64'd1) << 16;
   localparam logic [XLEN-1:0] MIE_MASK  = XLEN'(PLAT_MASK | 64'h888);
   localparam logic [XLEN-1:0] LOW2      = XLEN'(3);

   state_t            state;
   logic [2:0]        cnt;
   logic              st_mie, st_mpie;
   logic [XLEN-1:0]   mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
   logic [XLEN-1:0]   mip, pending, base, mepc_rd, target;
   logic [4:0]        irq_cause;
   logic              idle, exc_dec, irq_dec, mret_dec;

   always_comb begin
      mip     = '0;
      mip[3]  = irq_sw;
      mip[7]  = irq_timer;
      mip[11] = irq_ext;
      for (int i = 0; i < NUM_IRQ; i++) mip[16+i] = irq_plat[i];
   end

   assign pending = mip & mie_q;

   // Later assignments win: plat (lowest index) < timer < sw < ext.
   always_comb begin
      irq_cause = 5'd0;
      for (int i = NUM_IRQ-1; i >= 0; i--)
         if (pending[16+i]) irq_cause = 5'(16+i);
      if (pending[7])  irq_cause = 5'd7;
      if (pending[3])  irq_cause = 5'd3;
      if (pending[11]) irq_cause = 5'd11;
   end

   assign idle     = (state == IDLE);
   assign exc_dec  = idle && retire_valid && retire_exc;
   assign irq_dec  = idle && retire_valid && !retire_exc && st_mie && (|pending);
   assign mret_dec = idle && retire_valid && !retire_exc && !irq_dec && retire_mret;
   assign wb_kill  = exc_dec || irq_dec;

   assign base    = mtvec_q & ~LOW2;
   assign mepc_rd = mepc_q & ~LOW2;

   always_comb begin
      target = base;
      if (mret_dec)                target = mepc_rd;
      else if (irq_dec && mtvec_q[0]) target = base + XLEN'({irq_cause, 2'b00});
   end

   always_comb begin
      csr_rdata = '0;
      case (csr_addr)
         12'h300: begin
            csr_rdata[3]     = st_mie;
            csr_rdata[7]     = st_mpie;
            csr_rdata[12:11] = 2'b11;
         end
         12'h304: csr_rdata = mie_q;
         12'h305: csr_rdata = mtvec_q;
         12'h340: csr_rdata = mscratch_q;
         12'h341: csr_rdata = mepc_rd;
         12'h342: csr_rdata = mcause_q;
         12'h343: csr_rdata = mtval_q;
         12'h344: csr_rdata = mip;
         default: csr_rdata = '0;
      endcase
   end

   // Trap updates take precedence over a same-cycle CSR write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_mie     <= 1'b0;
         st_mpie    <= 1'b0;
         mie_q      <= '0;
         mtvec_q    <= VECTORED_EN ? (RESET_MTVEC & ~XLEN'(2)) : (RESET_MTVEC & ~LOW2);
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
      end else if (exc_dec || irq_dec) begin
         mepc_q   <= retire_pc;
         mcause_q <= exc_dec ? {1'b0, {(XLEN-5){1'b0}}, retire_exc_code}
                             : {1'b1, {(XLEN-6){1'b0}}, irq_cause};
         mtval_q  <= exc_dec ? retire_tval : '0;
         st_mpie  <= st_mie;
         st_mie   <= 1'b0;
      end else begin
         if (idle && csr_we) begin
            case (csr_addr)
               12'h300: begin
                  st_mie  <= csr_wdata[3];
                  st_mpie <= csr_wdata[7];
               end
               12'h304: mie_q      <= csr_wdata & MIE_MASK;
               12'h305: mtvec_q    <= VECTORED_EN ? (csr_wdata & ~XLEN'(2)) : (csr_wdata & ~LOW2);
               12'h340: mscratch_q <= csr_wdata;
               12'h341: mepc_q     <= csr_wdata;
               12'h342: mcause_q   <= csr_wdata;
               12'h343: mtval_q    <= csr_wdata;
               default: ;
            endcase
         end
         if (mret_dec) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= 3'd0;
         trap_take <= 1'b0;
         trap_pc   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (exc_dec || irq_dec || mret_dec) begin
                  state     <= REDIR;
                  trap_take <= 1'b1;
                  trap_pc   <= target;
               end
            end
            REDIR: begin
               state     <= DRAIN;
               cnt       <= 3'(FLUSH_CYCLES - 1);
               trap_take <= 1'b0;
               trap_pc   <= '0;
            end
            DRAIN: begin
               if (cnt == 3'd0) state <= IDLE;
               else             cnt   <= cnt - 3'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wb_trap_unit.sv
// tb/tb_wb_trap_unit.sv - directed self-checking bench for wb_trap_unit
module tb_wb_trap_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        retire_valid, retire_exc, retire_mret;
   logic [31:0] retire_pc, retire_tval;
   logic [3:0]  retire_exc_code;
   logic        irq_sw, irq_timer, irq_ext;
   logic [3:0]  irq_plat;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata, csr_rdata, trap_pc;
   logic        wb_kill, trap_take;

   int n_cmp = 0;
   int n_err = 0;

   wb_trap_unit dut (
      .clk(clk), .rst(rst),
      .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_exc(retire_exc),
      .retire_exc_code(retire_exc_code), .retire_tval(retire_tval), .retire_mret(retire_mret),
      .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext), .irq_plat(irq_plat),
      .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
      .wb_kill(wb_kill), .trap_take(trap_take), .trap_pc(trap_pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
      csr_addr = addr;
      #1;
      check(tag, csr_rdata, exp);
   endtask

   task automatic wr(input logic [11:0] addr, input logic [31:0] data);
      csr_we = 1'b1; csr_addr = addr; csr_wdata = data;
      step();
      csr_we = 1'b0;
   endtask

   task automatic clear_retire();
      retire_valid = 0; retire_exc = 0; retire_mret = 0;
      retire_exc_code = 0; retire_pc = 0; retire_tval = 0;
   endtask

   initial begin
      rst = 0; clear_retire();
      irq_sw = 0; irq_timer = 0; irq_ext = 0; irq_plat = 0;
      csr_we = 0; csr_addr = 0; csr_wdata = 0;
      step(); step();
      check("rst_trap_take", trap_take, 0);
      check("rst_trap_pc", trap_pc, 0);
      check("rst_wb_kill", wb_kill, 0);
      rd(12'h300, 32'h1800, "rst_mstatus");
      rd(12'h305, 32'h0, "rst_mtvec");
      rst = 1;
      step();

      wr(12'h305, 32'h100);
      rd(12'h305, 32'h100, "mtvec_wr");

      // exception with colliding mscratch write
      retire_valid = 1; retire_exc = 1; retire_exc_code = 2;
      retire_pc = 32'h40; retire_tval = 32'h1234;
      csr_we = 1; csr_addr = 12'h340; csr_wdata = 32'hDEAD;
      #1;
      check("exc_wb_kill", wb_kill, 1);
      step();
      csr_we = 0;
      retire_exc_code = 5; retire_pc = 32'h60; retire_tval = 32'h99;
      #1;
      check("exc_take", trap_take, 1);
      check("exc_pc", trap_pc, 32'h100);
      check("redir_no_kill", wb_kill, 0);
      rd(12'h341, 32'h40, "exc_mepc");
      rd(12'h342, 32'h2, "exc_mcause");
      rd(12'h343, 32'h1234, "exc_mtval");
      rd(12'h340, 32'h0, "collide_mscratch");
      step();
      check("drain1_take", trap_take, 0);
      check("drain1_kill", wb_kill, 0);
      step();
      check("drain2_take", trap_take, 0);
      check("drain2_kill", wb_kill, 0);
      rd(12'h341, 32'h40, "drain_mepc_hold");
      step();
      check("idle_accept_kill", wb_kill, 1);
      step();
      clear_retire();
      #1;
      check("exc2_take", trap_take, 1);
      rd(12'h341, 32'h60, "exc2_mepc");
      rd(12'h342, 32'h5, "exc2_mcause");
      rd(12'h343, 32'h99, "exc2_mtval");
      step(); step(); step();

      // masked platform interrupt
      wr(12'h304, 32'h880);
      wr(12'h300, 32'h8);
      irq_plat = 4'b0010; retire_valid = 1; retire_pc = 32'h70;
      rd(12'h344, 32'h20000, "mip_plat");
      check("mask_no_kill", wb_kill, 0);
      step();
      check("mask_no_take", trap_take, 0);
      irq_plat = 0; retire_valid = 0;

      // pending interrupt without retire_valid
      irq_ext = 1;
      #1;
      check("novalid_kill", wb_kill, 0);
      step();
      check("novalid_take", trap_take, 0);

      // vectored interrupt, ext beats timer
      wr(12'h305, 32'h201);
      irq_timer = 1; retire_valid = 1; retire_pc = 32'h80;
      #1;
      check("irq_kill", wb_kill, 1);
      step();
      irq_timer = 0; irq_ext = 0; retire_valid = 0;
      #1;
      check("irq_take", trap_take, 1);
      check("irq_pc", trap_pc, 32'h22C);
      rd(12'h342, 32'h8000000B, "irq_mcause");
      rd(12'h341, 32'h80, "irq_mepc");
      rd(12'h343, 32'h0, "irq_mtval");
      rd(12'h300, 32'h1880, "irq_mstatus");
      step(); step(); step();

      // mret
      retire_valid = 1; retire_mret = 1;
      #1;
      check("mret_kill", wb_kill, 0);
      step();
      clear_retire();
      #1;
      check("mret_take", trap_take, 1);
      check("mret_pc", trap_pc, 32'h80);
      rd(12'h300, 32'h1888, "mret_mstatus");
      step(); step(); step();

      // sw beats timer
      wr(12'h304, 32'h888);
      irq_sw = 1; irq_timer = 1; retire_valid = 1; retire_pc = 32'h90;
      step();
      irq_sw = 0; irq_timer = 0; retire_valid = 0;
      #1;
      check("sw_pc", trap_pc, 32'h20C);
      rd(12'h342, 32'h80000003, "sw_mcause");
      step(); step(); step();

      wr(12'h7C0, 32'hFFFF);
      rd(12'h7C0, 32'h0, "unmapped_rd");
      wr(12'h341, 32'h123);
      rd(12'h341, 32'h120, "mepc_low_bits");
      wr(12'h340, 32'hBEEF);
      rd(12'h340, 32'hBEEF, "mscratch_wr");

      // reset mid-drain
      retire_valid = 1; retire_exc = 1; retire_exc_code = 4; retire_pc = 32'hA0;
      step();
      clear_retire();
      step();
      rst = 0;
      #1;
      check("rst_drain_take", trap_take, 0);
      check("rst_drain_pc", trap_pc, 0);
      step();
      rst = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("post_rst_no_take", trap_take, 0);
      end
      rd(12'h300, 32'h1800, "post_rst_mstatus");
      rd(12'h304, 32'h0, "post_rst_mie");
      rd(12'h305, 32'h0, "post_rst_mtvec");
      rd(12'h340, 32'h0, "post_rst_mscratch");
      rd(12'h341, 32'h0, "post_rst_mepc");
      rd(12'h342, 32'h0, "post_rst_mcause");
      rd(12'h343, 32'h0, "post_rst_mtval");
      retire_valid = 1; retire_exc = 1; retire_exc_code = 1; retire_pc = 32'hB0;
      #1;
      check("post_rst_idle_kill", wb_kill, 1);
      step();
      clear_retire();
      #1;
      check("post_rst_take", trap_take, 1);
      check("post_rst_pc", trap_pc, 32'h0);
      step(); step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/wb_trap_unit.md
WB_TRAP_UNIT -- requirements
Module: wb_trap_unit

Parameters
REQ-001 XLEN, default 32, data/PC width; the machine CSRs are XLEN wide.
REQ-002 NUM_IRQ, default 4 (range 0..16), platform interrupt lines; line i uses cause 16+i.
REQ-003 VECTORED_EN, default 1; when 0, mtvec.MODE reads 0 and writes to it are ignored.
REQ-004 FLUSH_CYCLES, default 2 (range 1..7), drain cycles after each redirect.
REQ-005 RESET_MTVEC, default 0, reset value of mtvec.

Interface
REQ-006 One clock; reset is asynchronous and active-low. Ports: clk (input), rst (input, async active-low).
REQ-007 Remaining ports (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  async active-low reset.
- retire_valid  in  1  instruction present in WB.
- retire_pc  in  XLEN  its PC.
- retire_exc  in  1  instruction carries an exception.
- retire_exc_code  in  4  exception cause code.
- retire_tval  in  XLEN  fault address or instruction.
- retire_mret  in  1  instruction is mret.
- irq_sw  in  1  machine software interrupt level.
- irq_timer  in  1  machine timer interrupt level.
- irq_ext  in  1  machine external interrupt level.
- irq_plat  in  NUM_IRQ  platform interrupt levels.
- csr_we  in  1  CSR write strobe.
- csr_addr  in  12  CSR address.
- csr_wdata  in  XLEN  CSR write data.
- csr_rdata  out  XLEN  CSR read data, combinational.
- wb_kill  out  1  suppress register write of the retiring instruction, combinational.
- trap_take  out  1  one-cycle redirect pulse, registered.
- trap_pc  out  XLEN  redirect target, registered.

Function
REQ-008 CSR map:
- mstatus 0x300: MIE bit 3, MPIE bit 7, MPP bits 12:11 read 2'b11.
- mie 0x304: bits 3, 7, 11 and 16..16+NUM_IRQ-1 writable.
- mtvec 0x305.
- mscratch 0x340.
- mepc 0x341: bits 1:0 read 0.
- mcause 0x342.
- mtval 0x343.
- mip 0x344: read-only.
- Any other address reads 0 and ignores writes.
REQ-009 mip reflects the current irq_sw, irq_timer, irq_ext and irq_plat levels at bits 3, 7, 11 and 16+i.
REQ-010 FSM states: IDLE, REDIR, DRAIN.
REQ-011 A decision is made only in IDLE with retire_valid=1, in this priority order:
- exception (retire_exc=1);
- interrupt (mstatus.MIE=1 and (mip & mie) != 0);
- mret (retire_mret=1).
REQ-012 Interrupt priority: ext (cause 11) > sw (3) > timer (7) > irq_plat lowest index first.
REQ-013 In the decision cycle, wb_kill=1 for exception and interrupt; wb_kill=0 for mret and in all other cycles.
REQ-014 Exception or interrupt decision, updated at the next edge:
- mepc <= retire_pc.
- mcause <= {interrupt flag, cause}.
- mtval <= retire_tval for an exception, 0 for an interrupt.
- MPIE <= MIE; MIE <= 0.
REQ-015 mret decision, updated at the next edge: MIE <= MPIE; MPIE <= 1.
REQ-016 Redirect target:
- exception: mtvec base (mtvec with bits 1:0 cleared);
- interrupt: base + 4*cause when mtvec.MODE=1, else base;
- mret: mepc.
REQ-017 Any decision moves the FSM to REDIR. In REDIR, trap_take=1 and trap_pc holds the registered target for exactly one cycle.
REQ-018 DRAIN lasts FLUSH_CYCLES cycles, timed by a down-counter, then the FSM returns to IDLE.
REQ-019 Outside IDLE, retire_* inputs and csr_we are ignored.
REQ-020 csr_we applies at the clock edge only in IDLE and only when no exception or interrupt is decided that cycle. The trap update wins over a same-cycle CSR write.
REQ-021 Decisions are latched at the decision edge. Interrupt lines deasserting after the decision do not alter mcause or trap_pc.
REQ-022 retire_valid=0 in IDLE: no decision and no state change, even if an interrupt is pending.

Reset
REQ-023 rst=0 asynchronously forces:
- FSM to IDLE, counter 0;
- trap_take=0, trap_pc=0;
- MIE=0, MPIE=0;
- mie=0, mscratch=0, mepc=0, mcause=0, mtval=0;
- mtvec=RESET_MTVEC.
REQ-024 A reset asserted in REDIR or DRAIN aborts the redirect: no trap_take pulse appears after reset is released.

Verification
REQ-025 Exception path. Setup: mtvec=0x100. Stimulus: retire_valid=1, retire_exc=1, code 2, pc=0x40, tval=0x1234.
- Decision cycle: wb_kill=1.
- Next cycle: trap_take=1, trap_pc=0x100.
- CSRs: mepc=0x40, mcause=0x2, mtval=0x1234.
REQ-026 Vectored interrupt. Setup: mtvec=0x201, mie=0x880, MIE=1. Stimulus: irq_timer=1, irq_ext=1, retire_valid=1, pc=0x80.
- trap_pc=0x22C.
- mcause=0x8000000B.
- MIE=0, MPIE=1.
REQ-027 mret. Setup: mepc=0x80, MPIE=1. Stimulus: retire_mret=1.
- wb_kill=0.
- Next cycle: trap_take=1, trap_pc=0x80.
- MIE=1, MPIE=1.
REQ-028 Drain blocking, FLUSH_CYCLES=2. Stimulus: a second exception presented during REDIR and both DRAIN cycles.
- No trap_take and no CSR change.
- The exception is accepted on the first IDLE cycle.
REQ-029 Masking and collision.
- Platform irq_plat[1] pending with mie bit 17 clear: no trap.
- csr_we to mscratch in the same cycle as an exception: mscratch unchanged.
REQ-030 Reset mid-drain. Assert rst=0 during DRAIN:
- trap_take=0 immediately;
- after release, the FSM is in IDLE and all CSRs hold their reset values.
